// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: datapath width, lane count and the
// state encoding used by the butterfly output commutator.
package fft_pkg;

   localparam int FFT_DW    = 12;
   localparam int FFT_LANES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } cmt_state_t;

endpackage

// File: rtl/bfly_out_commutator_if.sv
// Butterfly-output bus: parallel sum/difference blocks in, one serialized
// 16-lane stream out.
interface bfly_out_commutator_if #(
   parameter int DATA_WIDTH = fft_pkg::FFT_DW,
   parameter int LANES      = fft_pkg::FFT_LANES,
   parameter int DEPTH      = 2
);

   localparam int BW = $clog2(2 * DEPTH);

   // Handshake: din_valid qualifies din_* for exactly one cycle and there is
   // no ready; a block offered while the commutator is draining is dropped
   // and latches overrun. dout_valid qualifies dout_* for that cycle only.
   logic                              din_valid;
   logic [LANES-1:0][DATA_WIDTH-1:0]  din_add_r;
   logic [LANES-1:0][DATA_WIDTH-1:0]  din_add_i;
   logic [LANES-1:0][DATA_WIDTH-1:0]  din_sub_r;
   logic [LANES-1:0][DATA_WIDTH-1:0]  din_sub_i;
   logic                              dout_valid;
   logic [LANES-1:0][DATA_WIDTH-1:0]  dout_r;
   logic [LANES-1:0][DATA_WIDTH-1:0]  dout_i;
   logic [BW-1:0]                     dout_blk;
   logic                              dout_last;
   logic                              overrun;

   modport master (
      output din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i,
      input  dout_valid, dout_r, dout_i, dout_blk, dout_last, overrun
   );

   modport slave (
      input  din_valid, din_add_r, din_add_i, din_sub_r, din_sub_i,
      output dout_valid, dout_r, dout_i, dout_blk, dout_last, overrun
   );

endinterface

// File: rtl/bfly_sub_buf.sv
// Holding bank for the difference blocks of one butterfly burst; written
// while the sum blocks stream out, read back combinationally during drain.
module bfly_sub_buf #(
   parameter int DATA_WIDTH = fft_pkg::FFT_DW,
   parameter int LANES      = fft_pkg::FFT_LANES,
   parameter int DEPTH      = 2,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                              clk,
   input  logic                              we,
   input  logic [AW-1:0]                     waddr,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]  wdata_r,
   input  logic [LANES-1:0][DATA_WIDTH-1:0]  wdata_i,
   input  logic [AW-1:0]                     raddr,
   output logic [LANES-1:0][DATA_WIDTH-1:0]  rdata_r,
   output logic [LANES-1:0][DATA_WIDTH-1:0]  rdata_i
);

   logic [LANES-1:0][DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [LANES-1:0][DATA_WIDTH-1:0] mem_i [DEPTH];

   // Contents are don't-care after reset, so the bank carries no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata_r;
         mem_i[waddr] <= wdata_i;
      end
   end

   assign rdata_r = mem_r[raddr];
   assign rdata_i = mem_i[raddr];

endmodule

// File: rtl/bfly_out_commutator.sv
// Re-serializes a butterfly burst: sum blocks pass straight through, the
// difference blocks are parked and emitted afterwards in arrival order.
module bfly_out_commutator
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DW,
   parameter int LANES      = FFT_LANES,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   bfly_out_commutator_if.slave  bus,
   output cmt_state_t            state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = $clog2(2 * DEPTH);

   typedef logic [LANES-1:0][DATA_WIDTH-1:0] lanes_t;

   cmt_state_t     state_q, state_d;
   logic [AW-1:0]  wr_cnt, wr_cnt_d;
   logic [AW-1:0]  rd_cnt, rd_cnt_d;
   logic [BW-1:0]  blk_d;
   logic           accept, drop, wr_last, rd_last;
   logic           load_add, load_sub, emit_last;
   lanes_t         buf_r, buf_i;

   assign accept  = bus.din_valid && (state_q != DRAIN);
   assign drop    = bus.din_valid && (state_q == DRAIN);
   assign wr_last = (wr_cnt == AW'(DEPTH - 1));
   assign rd_last = (rd_cnt == AW'(DEPTH - 1));
   assign state   = state_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // wr_cnt is always 0 in IDLE, so wr_last there means DEPTH == 1.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.din_valid) state_d = wr_last ? DRAIN : FILL;
         FILL:    if (bus.din_valid && wr_last) state_d = DRAIN;
         DRAIN:   if (rd_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_add  = 1'b0;
      load_sub  = 1'b0;
      emit_last = 1'b0;
      wr_cnt_d  = wr_cnt;
      rd_cnt_d  = rd_cnt;
      blk_d     = BW'(wr_cnt);
      case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               load_add = 1'b1;
               wr_cnt_d = wr_last ? '0 : wr_cnt + 1'b1;
               rd_cnt_d = '0;
            end
         end
         DRAIN: begin
            load_sub  = 1'b1;
            emit_last = rd_last;
            blk_d     = BW'(DEPTH) + BW'(rd_cnt);
            rd_cnt_d  = rd_last ? '0 : rd_cnt + 1'b1;
         end
         default: ;
      endcase
   end

   bfly_sub_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_sub_buf (
      .clk     (clk),
      .we      (accept),
      .waddr   (wr_cnt),
      .wdata_r (bus.din_sub_r),
      .wdata_i (bus.din_sub_i),
      .raddr   (rd_cnt),
      .rdata_r (buf_r),
      .rdata_i (buf_i)
   );

   // Data and block index hold between valid cycles; only valid/last drop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt         <= '0;
         rd_cnt         <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_r     <= '0;
         bus.dout_i     <= '0;
         bus.dout_blk   <= '0;
         bus.dout_last  <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         wr_cnt         <= wr_cnt_d;
         rd_cnt         <= rd_cnt_d;
         bus.dout_valid <= load_add || load_sub;
         bus.dout_last  <= emit_last;
         if (load_add) begin
            bus.dout_r   <= bus.din_add_r;
            bus.dout_i   <= bus.din_add_i;
            bus.dout_blk <= blk_d;
         end else if (load_sub) begin
            bus.dout_r   <= buf_r;
            bus.dout_i   <= buf_i;
            bus.dout_blk <= blk_d;
         end
         if (drop) bus.overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bfly_out_commutator.sv
// Directed bench for the butterfly output commutator at DEPTH=2, 16 lanes.
module tb_bfly_out_commutator;
   import fft_pkg::*;

   localparam int DW = 12;
   localparam int LN = 16;
   localparam int DP = 2;

   typedef logic [LN-1:0][DW-1:0] lanes_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   cmt_state_t state;
   int         n_checks = 0;
   int         n_pass = 0;

   bfly_out_commutator_if #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP)) bus ();

   bfly_out_commutator #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus),
      .state (state)
   );

   always #5 clk = ~clk;

   // lane i = base + i, optionally negated, as 12-bit two's complement
   function automatic lanes_t ramp(input int base, input bit neg);
      lanes_t r;
      for (int i = 0; i < LN; i++) begin
         int v;
         v = base + i;
         if (neg) v = -v;
         r[i] = DW'(v);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input lanes_t ar, input lanes_t ai,
                        input lanes_t sr, input lanes_t si);
      bus.din_valid = v;
      bus.din_add_r = ar;
      bus.din_add_i = ai;
      bus.din_sub_r = sr;
      bus.din_sub_i = si;
   endtask

   task automatic drive_ramp(input int base);
      drive(1'b1, ramp(base, 1'b0), ramp(base + 256, 1'b0),
            ramp(base, 1'b1), ramp(base + 256, 1'b1));
   endtask

   task automatic drive_idle();
      bus.din_valid = 1'b0;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_out(input string tag, input lanes_t r, input lanes_t i,
                            input int blk, input logic last);
      check({tag, ".valid"}, 256'(bus.dout_valid), 256'(1'b1));
      check({tag, ".r"},     256'(bus.dout_r),     256'(r));
      check({tag, ".i"},     256'(bus.dout_i),     256'(i));
      check({tag, ".blk"},   256'(bus.dout_blk),   256'(blk));
      check({tag, ".last"},  256'(bus.dout_last),  256'(last));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 256'(bus.dout_valid), 256'(1'b0));
      check({tag, ".last"},  256'(bus.dout_last),  256'(1'b0));
   endtask

   // Sum blocks of a burst carry base/base+16, difference blocks their negation.
   task automatic check_add(input string tag, input int base, input int blk);
      check_out(tag, ramp(base, 1'b0), ramp(base + 256, 1'b0), blk, 1'b0);
   endtask

   task automatic check_sub(input string tag, input int base, input int blk, input logic last);
      check_out(tag, ramp(base, 1'b1), ramp(base + 256, 1'b1), blk, last);
   endtask

   task automatic single_burst(input string tag, input int base);
      drive_ramp(base);
      tick();
      check_add({tag, ".b0"}, base, 0);
      check({tag, ".st_fill"}, 256'(state), 256'(FILL));
      drive_ramp(base + 16);
      tick();
      check_add({tag, ".b1"}, base + 16, 1);
      check({tag, ".st_drain"}, 256'(state), 256'(DRAIN));
      drive_idle();
      tick();
      check_sub({tag, ".b2"}, base, 2, 1'b0);
      tick();
      check_sub({tag, ".b3"}, base + 16, 3, 1'b1);
      check({tag, ".st_idle"}, 256'(state), 256'(IDLE));
      tick();
      check_idle({tag, ".after"});
   endtask

   initial begin
      lanes_t lo, hi, mix_a, mix_b;

      // reset state
      drive(1'b0, '0, '0, '0, '0);
      tick();
      tick();
      check("rst.valid",   256'(bus.dout_valid), 256'(0));
      check("rst.r",       256'(bus.dout_r),     256'(0));
      check("rst.i",       256'(bus.dout_i),     256'(0));
      check("rst.blk",     256'(bus.dout_blk),   256'(0));
      check("rst.last",    256'(bus.dout_last),  256'(0));
      check("rst.overrun", 256'(bus.overrun),    256'(0));
      check("rst.state",   256'(state),          256'(IDLE));
      rstn = 1'b1;
      tick();

      single_burst("single", 0);

      // eight back-to-back bursts: gapless output, blk 0..3 repeating
      for (int b = 0; b < 8; b++) begin
         for (int c = 0; c < 4; c++) begin
            if (c < 2) drive_ramp(32 * b + 16 * c);
            else       drive_idle();
            tick();
            if (c < 2) check_add($sformatf("b2b%0d.%0d", b, c), 32 * b + 16 * c, c);
            else       check_sub($sformatf("b2b%0d.%0d", b, c), 32 * b + 16 * (c - 2), c, c == 3);
            check($sformatf("b2b%0d.%0d.ovr", b, c), 256'(bus.overrun), 256'(0));
         end
      end
      tick();
      check_idle("b2b.end");

      // one-cycle gap inside FILL
      drive_ramp(500);
      tick();
      check_add("gap.b0", 500, 0);
      drive_idle();
      tick();
      check_idle("gap.bubble");
      check("gap.st_hold", 256'(state), 256'(FILL));
      drive_ramp(516);
      tick();
      check_add("gap.b1", 516, 1);
      drive_idle();
      tick();
      check_sub("gap.b2", 500, 2, 1'b0);
      tick();
      check_sub("gap.b3", 516, 3, 1'b1);
      tick();

      // overrun: a block offered at the first drain edge is dropped
      drive_ramp(600);
      tick();
      check_add("ovr.b0", 600, 0);
      drive_ramp(616);
      tick();
      check_add("ovr.b1", 616, 1);
      check("ovr.pre", 256'(bus.overrun), 256'(0));
      drive_ramp(1000);
      tick();
      check("ovr.set", 256'(bus.overrun), 256'(1));
      check_sub("ovr.b2", 600, 2, 1'b0);
      drive_idle();
      tick();
      check_sub("ovr.b3", 616, 3, 1'b1);
      tick();
      check_idle("ovr.after");
      check("ovr.sticky", 256'(bus.overrun), 256'(1));
      check("ovr.st", 256'(state), 256'(IDLE));

      // reset in the middle of the drain
      drive_ramp(700);
      tick();
      drive_ramp(716);
      tick();
      drive_idle();
      tick();
      check_sub("mid.b2", 700, 2, 1'b0);
      rstn = 1'b0;
      #1;
      check("mid.valid",   256'(bus.dout_valid), 256'(0));
      check("mid.r",       256'(bus.dout_r),     256'(0));
      check("mid.i",       256'(bus.dout_i),     256'(0));
      check("mid.blk",     256'(bus.dout_blk),   256'(0));
      check("mid.last",    256'(bus.dout_last),  256'(0));
      check("mid.overrun", 256'(bus.overrun),    256'(0));
      check("mid.state",   256'(state),          256'(IDLE));
      #2;
      rstn = 1'b1;
      tick();
      check_idle("mid.released");
      single_burst("post_rst", 0);

      // full-scale lanes must pass without sign corruption
      for (int i = 0; i < LN; i++) begin
         lo[i]    = 12'h800;
         hi[i]    = 12'h7FF;
         mix_a[i] = i[0] ? 12'h800 : 12'h7FF;
         mix_b[i] = i[0] ? 12'h7FF : 12'h800;
      end
      drive(1'b1, lo, hi, hi, lo);
      tick();
      check_out("ext.b0", lo, hi, 0, 1'b0);
      drive(1'b1, mix_a, mix_b, mix_b, mix_a);
      tick();
      check_out("ext.b1", mix_a, mix_b, 1, 1'b0);
      drive_idle();
      tick();
      check_out("ext.b2", hi, lo, 2, 1'b0);
      tick();
      check_out("ext.b3", mix_b, mix_a, 3, 1'b1);
      tick();
      check_idle("ext.after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bfly_out_commutator.md
# bfly_out_commutator

Output-side commutator for the radix-2 butterfly stages of the 512-point FFT pipeline. It accepts a butterfly burst carrying parallel sum (A+B) and difference (A−B) blocks of 16 lanes each. It re-serializes them into a single 16-lane stream: all sum blocks first, then all difference blocks. This is the reverse of the input-side delay/shift-register that pairs A and B. The stream it produces feeds the twiddle multiplier and the next stage's delay line.

## Interface
Parameters:
- DATA_WIDTH, 12: bit width of each real/imag lane (butterfly output width).
- LANES, 16: samples per clock.
- DEPTH, 2: input cycles per butterfly burst. This equals the butterfly's CLK_CNT.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- din_valid  in  1  qualifies din_* for one cycle.
- din_add_r / din_add_i  in  LANES×DATA_WIDTH signed  sum lanes [0:LANES-1].
- din_sub_r / din_sub_i  in  LANES×DATA_WIDTH signed  difference lanes [0:LANES-1].
- dout_valid  out  1  dout_* valid this cycle.
- dout_r / dout_i  out  LANES×DATA_WIDTH signed  serialized lanes.
- dout_blk  out  $clog2(2*DEPTH)  block index within a burst (0..2*DEPTH-1).
- dout_last  out  1  high with the final difference block of a burst.
- overrun  out  1  sticky error flag, cleared only by reset.

## Operation
- FSM states:
  - IDLE: no burst in progress.
  - FILL: accepting the sum and difference blocks of a burst.
  - DRAIN: emitting buffered difference blocks.
- IDLE + din_valid:
  - Register the add block to dout.
  - Write the sub block to slot 0 of the difference buffer.
  - wr_cnt becomes 1.
  - Go to FILL, or go directly to DRAIN when DEPTH=1.
- FILL + din_valid:
  - Register the add block to dout.
  - Store the sub block in slot wr_cnt.
  - Increment wr_cnt.
  - When wr_cnt reaches DEPTH: go to DRAIN and set rd_cnt to 0.
- FILL without din_valid: gaps are allowed. dout_valid is 0 during a gap and state and counters hold.
- DRAIN:
  - Each cycle, register buffer slot rd_cnt to dout and increment rd_cnt.
  - When the last slot is emitted: assert dout_last and go to IDLE.
- din_valid while in DRAIN is an overrun:
  - The input is dropped.
  - overrun sets to 1 and stays set.
  - The drain continues unaffected.
- dout_blk: takes wr_cnt (0..DEPTH-1) for sum blocks and DEPTH+rd_cnt for difference blocks.
- No arithmetic is performed. Lanes pass bit-exact with no width change. Lane order is preserved.
- Reset mid-burst:
  - All outputs, counters and state return to reset values at once.
  - Buffered data is discarded and need not be cleared.

## Timing
- All outputs are registered. Latency is 1 cycle from the din_valid edge to the first dout.
- DEPTH=2, in_valid at edges k and k+1 produces:
  - dout = add0 (blk 0) after edge k.
  - dout = add1 (blk 1) after edge k+1.
  - dout = sub0 (blk 2) after edge k+2.
  - dout = sub1 (blk 3, last) after edge k+3.
  - State returns to IDLE at edge k+3.
- Minimum burst spacing is 2*DEPTH cycles. A new burst starting at edge k+4 gives gapless output with dout_valid held at 1.
- din_valid at edge k+2 or k+3 is an overrun. overrun is visible after that same edge.
- Reset values: dout_valid=0, dout_r/dout_i=all 0, dout_blk=0, dout_last=0, overrun=0, state=IDLE.

## Structure
- Shared package fft_pkg holds:
  - the FFT_DW constant (12);
  - the FFT_LANES constant (16);
  - the commutator state enum typedef, cmt_state_t {IDLE, FILL, DRAIN}.
- Sub-module bfly_sub_buf is a DEPTH×LANES register bank (real+imag). It has a write port (we, waddr) and a combinational read port (raddr). It has no reset.
- The top level contains the FSM, counters, output mux and output registers.

## Test plan
- Single burst, DEPTH=2. Inputs: add lanes = lane index + 16*cycle, sub lanes = −(same value). Required output, on 4 consecutive cycles:
  - blks 0,1 carry 0..15 and 16..31.
  - blks 2,3 carry −0..−15 and −16..−31.
  - dout_last is high on blk 3 only.
- Back-to-back bursts every 4 cycles, 8 bursts: dout_valid is continuously 1 for 32 cycles; dout_blk sequence repeats 0,1,2,3; overrun stays 0.
- Gap in FILL: din_valid at k, idle at k+1, valid at k+2. Required: add0 after k, a dout_valid=0 bubble, then add1, sub0, sub1 on consecutive cycles.
- Overrun: assert din_valid at edge k+2 of a burst. Required: overrun=1 from that edge; the sub0/sub1 outputs are unchanged; the dropped data never appears.
- Reset mid-DRAIN: deassert rstn after sub0. Required: all outputs go to 0 immediately. A burst after reset release behaves as in the single-burst test.
- Extreme values: lanes at −2048 and +2047. Required: output is bit-exact with no sign corruption.
